// File: rtl/store_capture_pkg.sv
// Shared types for the store-capture responder: FSM states and the FIFO entry layout.
package store_capture_pkg;

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    PASS = 2'd1,
    FAIL = 2'd2
  } cap_state_t;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } cap_entry_t;

  localparam int CAP_W = 64;

endpackage

// File: rtl/store_capture_sync_fifo.sv
// Single-clock FIFO with an explicit occupancy counter; a push into a full FIFO
// succeeds only when a pop happens in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 8
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           clear,
  input  logic                           push,
  input  logic                           pop,
  input  logic [WIDTH-1:0]               wdata,
  output logic [WIDTH-1:0]               rdata,
  output logic                           full,
  output logic                           empty,
  output logic [$clog2(DEPTH+1)-1:0]     count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CW'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  always_comb begin
    count_d = count_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (clear) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      count_q <= count_d;
    end
  end

  // Storage needs no reset: occupancy alone decides what is visible.
  always_ff @(posedge clk) begin
    if (do_push && !clear) mem_q[wr_ptr_q] <= wdata;
  end

  assign rdata = empty ? '0 : mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/store_capture.sv
// Store-capture responder: windows core stores into a drainable FIFO and
// latches PASS/FAIL when the completion store (or an out-of-window store) arrives.
module store_capture
  import store_capture_pkg::*;
#(
  parameter int          DEPTH     = 8,
  parameter logic [31:0] WIN_LO    = 32'h0000_0000,
  parameter logic [31:0] WIN_HI    = 32'h0000_00FF,
  parameter logic [31:0] DONE_ADR  = 32'd84,
  parameter logic [31:0] DONE_DATA = 32'd7
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       clear,
  input  logic                       memwrite,
  input  logic [31:0]                dataadr,
  input  logic [31:0]                writedata,
  output logic                       cap_valid,
  input  logic                       cap_ready,
  output logic [31:0]                cap_addr,
  output logic [31:0]                cap_data,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       overflow,
  output logic                       done,
  output logic                       pass
);

  cap_state_t  state_q, state_d;
  logic        overflow_q, overflow_d;
  logic [31:0] win_off;
  logic        inwin, push, full, empty;
  cap_entry_t  wr_entry, head_entry;

  // Offset form keeps the range check unsigned and free of constant compares.
  assign win_off = dataadr - WIN_LO;
  assign inwin   = (win_off <= (WIN_HI - WIN_LO));
  assign push    = memwrite & inwin & (state_q == RUN) & ~clear;

  assign wr_entry.addr = dataadr;
  assign wr_entry.data = writedata;

  always_comb begin
    state_d = state_q;
    if (state_q == RUN && memwrite) begin
      if (dataadr == DONE_ADR)
        state_d = (writedata == DONE_DATA) ? PASS : FAIL;
      else if (!inwin)
        state_d = FAIL;
    end
    if (clear) state_d = RUN;
  end

  // Full implies non-empty, so cap_ready alone tells whether a pop frees a slot.
  always_comb begin
    overflow_d = overflow_q | (push & full & ~cap_ready);
    if (clear) overflow_d = 1'b0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= RUN;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      overflow_q <= overflow_d;
    end
  end

  sync_fifo #(
    .WIDTH (CAP_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .clear (clear),
    .push  (push),
    .pop   (cap_ready),
    .wdata (wr_entry),
    .rdata (head_entry),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  assign cap_valid = ~empty;
  assign cap_addr  = head_entry.addr;
  assign cap_data  = head_entry.data;
  assign overflow  = overflow_q;
  assign done      = (state_q != RUN);
  assign pass      = (state_q == PASS);

endmodule

// File: tb/tb_store_capture.sv
// Self-checking bench for store_capture: vector table, directed corner sequences,
// then randomized traffic against a queue-based reference model.
module tb_store_capture;

  localparam int          DEPTH     = 8;
  localparam logic [31:0] WIN_LO    = 32'h0000_0000;
  localparam logic [31:0] WIN_HI    = 32'h0000_00FF;
  localparam logic [31:0] DONE_ADR  = 32'd84;
  localparam logic [31:0] DONE_DATA = 32'd7;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        clear = 1'b0;
  logic        memwrite = 1'b0;
  logic [31:0] dataadr = '0;
  logic [31:0] writedata = '0;
  logic        cap_ready = 1'b0;
  logic        cap_valid;
  logic [31:0] cap_addr, cap_data;
  logic [3:0]  count;
  logic        overflow, done, pass;

  always #5 clk = ~clk;

  store_capture #(
    .DEPTH(DEPTH), .WIN_LO(WIN_LO), .WIN_HI(WIN_HI),
    .DONE_ADR(DONE_ADR), .DONE_DATA(DONE_DATA)
  ) dut (
    .clk(clk), .reset(reset), .clear(clear), .memwrite(memwrite),
    .dataadr(dataadr), .writedata(writedata), .cap_valid(cap_valid),
    .cap_ready(cap_ready), .cap_addr(cap_addr), .cap_data(cap_data),
    .count(count), .overflow(overflow), .done(done), .pass(pass)
  );

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp)
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    else
      n_pass++;
  endtask

  // Reference model: ordered queue of captured stores plus a 3-valued outcome.
  typedef struct packed { logic [31:0] addr; logic [31:0] data; } ent_t;
  ent_t m_q[$];
  int   m_state = 0;  // 0 running, 1 passed, 2 failed
  bit   m_ovf = 0;

  function automatic bit in_window(input logic [31:0] a);
    return (longint'(a) >= longint'(WIN_LO)) && (longint'(a) <= longint'(WIN_HI));
  endfunction

  task automatic model_reset();
    m_q.delete();
    m_state = 0;
    m_ovf = 0;
  endtask

  task automatic model_step(input bit clr, input bit mw, input logic [31:0] a,
                            input logic [31:0] d, input bit rdy);
    ent_t e;
    if (clr) begin
      model_reset();
      return;
    end
    if (rdy && m_q.size() > 0) void'(m_q.pop_front());
    if (mw && m_state == 0) begin
      if (in_window(a)) begin
        e.addr = a; e.data = d;
        if (m_q.size() < DEPTH) m_q.push_back(e);
        else m_ovf = 1;
      end
      if (a == DONE_ADR) m_state = (d == DONE_DATA) ? 1 : 2;
      else if (!in_window(a)) m_state = 2;
    end
  endtask

  task automatic model_check(input string tag);
    chk({tag, ".count"}, 32'(count), 32'(m_q.size()));
    chk({tag, ".valid"}, 32'(cap_valid), 32'(m_q.size() > 0));
    chk({tag, ".addr"}, cap_addr, (m_q.size() > 0) ? m_q[0].addr : 32'h0);
    chk({tag, ".data"}, cap_data, (m_q.size() > 0) ? m_q[0].data : 32'h0);
    chk({tag, ".done"}, 32'(done), 32'(m_state != 0));
    chk({tag, ".pass"}, 32'(pass), 32'(m_state == 1));
    chk({tag, ".ovf"}, 32'(overflow), 32'(m_ovf));
  endtask

  // Drive one cycle of inputs, let one rising edge pass, sample 1ns later.
  task automatic drive(input bit clr, input bit mw, input logic [31:0] a,
                       input logic [31:0] d, input bit rdy);
    clear = clr; memwrite = mw; dataadr = a; writedata = d; cap_ready = rdy;
    model_step(clr, mw, a, d, rdy);
    @(posedge clk);
    #1;
    clear = 0; memwrite = 0; cap_ready = 0;
  endtask

  typedef struct {
    bit clr; bit mw; logic [31:0] adr; logic [31:0] dat; bit rdy;
    int cnt; bit vld; logic [31:0] haddr; logic [31:0] hdata; bit dn; bit ps; bit ov;
  } vec_t;
  vec_t tbl[14];

  initial begin
    // clr mw adr dat rdy | cnt vld haddr hdata done pass ovf
    tbl[0]  = '{0, 1, 32'h00, 1, 0,   1, 1, 32'h00, 1, 0, 0, 0};
    tbl[1]  = '{0, 1, 32'h04, 2, 0,   2, 1, 32'h00, 1, 0, 0, 0};
    tbl[2]  = '{0, 1, 32'h08, 3, 0,   3, 1, 32'h00, 1, 0, 0, 0};
    tbl[3]  = '{0, 0, 32'h00, 0, 1,   2, 1, 32'h04, 2, 0, 0, 0};
    tbl[4]  = '{0, 0, 32'h00, 0, 1,   1, 1, 32'h08, 3, 0, 0, 0};
    tbl[5]  = '{0, 0, 32'h00, 0, 1,   0, 0, 32'h00, 0, 0, 0, 0};
    tbl[6]  = '{0, 1, 32'd80, 5, 0,   1, 1, 32'd80, 5, 0, 0, 0};
    tbl[7]  = '{0, 1, 32'd84, 7, 1,   1, 1, 32'd84, 7, 1, 1, 0};
    tbl[8]  = '{0, 1, 32'h10, 9, 0,   1, 1, 32'd84, 7, 1, 1, 0};
    tbl[9]  = '{1, 1, 32'd84, 7, 0,   0, 0, 32'h00, 0, 0, 0, 0};
    tbl[10] = '{0, 1, 32'd84, 6, 0,   1, 1, 32'd84, 6, 1, 0, 0};
    tbl[11] = '{1, 0, 32'h00, 0, 0,   0, 0, 32'h00, 0, 0, 0, 0};
    tbl[12] = '{0, 1, 32'h200, 1, 0,  0, 0, 32'h00, 0, 1, 0, 0};
    tbl[13] = '{1, 0, 32'h00, 0, 0,   0, 0, 32'h00, 0, 0, 0, 0};

    #12;
    chk("rst.count", 32'(count), 0);
    chk("rst.valid", 32'(cap_valid), 0);
    chk("rst.addr", cap_addr, 0);
    chk("rst.data", cap_data, 0);
    chk("rst.done", 32'(done), 0);
    chk("rst.pass", 32'(pass), 0);
    chk("rst.ovf", 32'(overflow), 0);
    @(negedge clk);
    reset = 1;
    model_reset();

    for (int i = 0; i < 14; i++) begin
      drive(tbl[i].clr, tbl[i].mw, tbl[i].adr, tbl[i].dat, tbl[i].rdy);
      chk($sformatf("tbl%0d.count", i), 32'(count), 32'(tbl[i].cnt));
      chk($sformatf("tbl%0d.valid", i), 32'(cap_valid), 32'(tbl[i].vld));
      chk($sformatf("tbl%0d.addr", i), cap_addr, tbl[i].haddr);
      chk($sformatf("tbl%0d.data", i), cap_data, tbl[i].hdata);
      chk($sformatf("tbl%0d.done", i), 32'(done), 32'(tbl[i].dn));
      chk($sformatf("tbl%0d.pass", i), 32'(pass), 32'(tbl[i].ps));
      chk($sformatf("tbl%0d.ovf", i), 32'(overflow), 32'(tbl[i].ov));
      $display("vec %0d: count=%0d valid=%0b head=(%0h,%0h) done=%0b pass=%0b ovf=%0b",
               i, count, cap_valid, cap_addr, cap_data, done, pass, overflow);
    end

    // Nine stores into an eight-deep FIFO with no drain.
    for (int i = 0; i < 9; i++) drive(0, 1, 32'(i * 4), 32'(100 + i), 0);
    chk("ovf9.count", 32'(count), 8);
    chk("ovf9.ovf", 32'(overflow), 1);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("ovf9.head%0d.addr", i), cap_addr, 32'(i * 4));
      chk($sformatf("ovf9.head%0d.data", i), cap_data, 32'(100 + i));
      drive(0, 0, 0, 0, 1);
    end
    chk("ovf9.drained", 32'(cap_valid), 0);
    chk("ovf9.sticky", 32'(overflow), 1);
    drive(1, 0, 0, 0, 0);

    // Full FIFO with a simultaneous store and pop.
    for (int i = 0; i < 8; i++) drive(0, 1, 32'(i * 4), 32'(200 + i), 0);
    drive(0, 1, 32'h40, 32'hAA, 1);
    chk("fullpop.count", 32'(count), 8);
    chk("fullpop.ovf", 32'(overflow), 0);
    for (int i = 1; i < 8; i++) begin
      chk($sformatf("fullpop.head%0d", i), cap_data, 32'(200 + i));
      drive(0, 0, 0, 0, 1);
    end
    chk("fullpop.last.addr", cap_addr, 32'h40);
    chk("fullpop.last.data", cap_data, 32'hAA);
    drive(1, 0, 0, 0, 0);

    // Asynchronous reset while holding five entries in FAIL.
    for (int i = 0; i < 5; i++) drive(0, 1, 32'(i * 4), 32'(i), 0);
    drive(0, 1, 32'h300, 1, 0);
    chk("arst.pre.count", 32'(count), 5);
    chk("arst.pre.done", 32'(done), 1);
    chk("arst.pre.pass", 32'(pass), 0);
    @(negedge clk);
    reset = 0;
    #1;
    chk("arst.count", 32'(count), 0);
    chk("arst.valid", 32'(cap_valid), 0);
    chk("arst.addr", cap_addr, 0);
    chk("arst.data", cap_data, 0);
    chk("arst.done", 32'(done), 0);
    chk("arst.ovf", 32'(overflow), 0);
    model_reset();
    @(negedge clk);
    reset = 1;

    // Randomized traffic against the reference model.
    for (int n = 0; n < 1500; n++) begin
      bit          clr, mw, rdy;
      logic [31:0] a, d;
      int          sel;
      clr = (m_state != 0) ? ($urandom_range(3) == 0) : ($urandom_range(59) == 0);
      mw  = $urandom_range(2) != 0;
      rdy = $urandom_range(2) == 0;
      sel = $urandom_range(59);
      d   = $urandom_range(15);
      if (sel == 0) begin
        a = DONE_ADR;
        d = ($urandom_range(1) == 0) ? DONE_DATA : 32'($urandom_range(6));
      end else if (sel == 1) begin
        a = 32'h100 + $urandom_range(32'hFFFF);
      end else begin
        a = 32'($urandom_range(255));
        if (a == DONE_ADR) a = 32'd88;
      end
      drive(clr, mw, a, d, rdy);
      model_check($sformatf("rnd%0d", n));
      if (n % 100 == 0)
        $display("rnd %0d: count=%0d done=%0b pass=%0b ovf=%0b", n, count, done, pass, overflow);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/store_capture.md
# store_capture

Store-capture responder on the processor data-memory write port. It samples every `memwrite` cycle from the core and filters stores by an address window. Accepted stores are buffered as (address, data) entries in a FIFO with a valid/ready drain port. A pass/fail state machine terminates on a designated completion store. The block sits beside the data memory in simulation and FPGA self-test builds, and replaces ad-hoc store checking with a synthesizable end-of-program detector.

## Interface
Parameters:
- `DEPTH`, 8: FIFO entries; power of two, ≥2.
- `WIN_LO`, 32'h0000_0000: lowest accepted store address (inclusive).
- `WIN_HI`, 32'h0000_00FF: highest accepted store address (inclusive).
- `DONE_ADR`, 32'd84: completion store address.
- `DONE_DATA`, 32'd7: expected completion data.

Ports:
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `clear`  in  1  synchronous clear of FIFO, flags and state.
- `memwrite`  in  1  core store strobe.
- `dataadr`  in  32  core store address.
- `writedata`  in  32  core store data.
- `cap_valid`  out  1  head entry available.
- `cap_ready`  in  1  consumer accepts head.
- `cap_addr`  out  32  head entry address.
- `cap_data`  out  32  head entry data.
- `count`  out  $clog2(DEPTH+1)  entries held.
- `overflow`  out  1  sticky: accepted store dropped because FIFO was full.
- `done`  out  1  sticky: state is PASS or FAIL.
- `pass`  out  1  sticky: state is PASS.

## Operation
- Store event (`st`): rising edge with `memwrite`=1.
- In-window (`inwin`): `WIN_LO` ≤ `dataadr` ≤ `WIN_HI`, compared unsigned.
- State machine states: RUN, PASS, FAIL. Reset state is RUN.
  - RUN → PASS: `st` with `dataadr`==`DONE_ADR` and `writedata`==`DONE_DATA`.
  - RUN → FAIL: `st` with `dataadr`==`DONE_ADR` and any other data.
  - RUN → FAIL: `st` with !`inwin`.
  - PASS and FAIL are terminal. They exit only through `clear` or `reset`, both of which go to RUN.
- Push condition: `st` & `inwin` & state==RUN.
  - The completion store itself is pushed.
  - No pushes occur in PASS or FAIL.
- Pop condition: `cap_valid` & `cap_ready`.
- Full FIFO:
  - Push without a simultaneous pop: entry is dropped, `overflow` is set, and `count` stays at `DEPTH`.
  - Push with a simultaneous pop: both occur, and `count` is unchanged.
- Empty FIFO:
  - `cap_valid`=0, `cap_addr`=`cap_data`=0.
  - A pop request is ignored.
- Pointers are $clog2(DEPTH) bits and wrap modulo `DEPTH`.
- `count` is tracked separately and distinguishes full from empty.
- `clear` dominates a same-cycle push, pop and transition.
  - Empties the FIFO, zeroes `overflow` and returns to RUN.
  - The store sampled in that cycle is discarded.
- Asynchronous `reset` mid-stream has the same effect as `clear`, taking effect immediately. Storage contents are don't-care.

## Timing
- Reset values: `cap_valid`=0, `cap_addr`=0, `cap_data`=0, `count`=0, `overflow`=0, `done`=0, `pass`=0, state RUN.
- Capture latency:
  - A store sampled at edge N gives `cap_valid`=1 and the head fields after edge N, when the FIFO was empty.
  - `count` increments after edge N.
- `cap_addr` and `cap_data` are combinational reads of the head slot. They are stable while `cap_valid`=1 and `cap_ready`=0.
- `done` and `pass` update after the edge that samples the terminating store. They never toggle afterwards until `clear` or `reset`.
- There is no combinational path from `cap_ready` to `cap_valid`.
- Throughput: one push and one pop per cycle.

## Structure
- `store_capture_pkg`:
  - `cap_state_t` enum {RUN, PASS, FAIL}.
  - `cap_entry_t` packed struct {addr[31:0], data[31:0]}.
  - localparam `CAP_W`=64.
- Sub-module `sync_fifo` (params `WIDTH`, `DEPTH`):
  - Carries push/pop/clear and full/empty/count.
  - Same full-with-pop rule as above.
- The top level holds window and completion compare, the state register and the sticky flags.

## Test plan
- Stores to 0x00, 0x04, 0x08 with data 1, 2, 3, `cap_ready`=0 → `count`=3; head is (0x00,1). Then `cap_ready`=1 → pops in order over three cycles, then `cap_valid`=0.
- 9 in-window stores with no drain (`DEPTH`=8) → `count`=8, `overflow`=1. Drained entries are the first 8 in order.
- FIFO full, store plus `cap_ready`=1 in the same cycle → `count` stays 8, `overflow`=0, and the new entry is last.
- Store (80,5) then (84,7) → after the second edge `done`=1, `pass`=1. A further store (0x10,9) is not captured and the flags hold.
- Store (84,6) → `done`=1, `pass`=0. Separately, from RUN, store (0x200,1) → `done`=1, `pass`=0, and nothing captured.
- `reset` low while `count`=5 and FAIL → all outputs are at reset values immediately. `clear` asserted on the same cycle as a store (84,7) → `count`=0, `done`=0.
